mem_sync_bank: RTL and testbench

//  Parametrised single-port synchronous memory bank. Next generation of the
//  8x8 asynchronous memory: configurable width, depth and read latency.

---
 rtl/mem_sync_bank_if.sv | 31 +++
 rtl/mem_sync_bank.sv | 143 ++++++++++++++
 tb/tb_mem_sync_bank.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sync_bank_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_sync_bank_if                                           |
// | Description : Request/response bundle for the mem_sync_bank memory.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface mem_sync_bank_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic                  chip_en;
  logic                  read_write;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     data_out;
  logic                  rd_valid;
  logic                  ready;
  logic                  addr_err;

  modport master (
    output chip_en, read_write, address, data_in, byte_en,
    input  data_out, rd_valid, ready, addr_err
  );

  modport slave (
    input  chip_en, read_write, address, data_in, byte_en,
    output data_out, rd_valid, ready, addr_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_sync_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_sync_bank                                              |
// | Description : Single-port synchronous memory bank with byte enables,     |
// |               configurable read latency, out-of-range error pulse and    |
// |               automatic clear of the whole array after every reset.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_sync_bank #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 1 << ADDR_W,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic          clock,
  input  logic          reset,
  mem_sync_bank_if.slave bus
);
  localparam int                c_bytes     = DATA_W / 8;
  localparam logic [ADDR_W:0]   c_depth     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                ready_q, ready_d;
  logic                addr_err_q, addr_err_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [DATA_W-1:0]   pdata_q [RD_LAT];
  logic [DATA_W-1:0]   pdata_d [RD_LAT];
  logic [DATA_W-1:0]   mem_q   [DEPTH];

  logic                accept;
  logic                in_range;
  logic [DATA_W-1:0]   rd_word;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Clear sequencing, request decode, byte merge and read-pipeline advance.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ready_d    = ready_q;
    mem_we     = 1'b0;
    mem_waddr  = clr_addr_q;
    mem_wdata  = INIT_VAL;
    accept     = bus.chip_en && ready_q;
    in_range   = ({1'b0, bus.address} < c_depth);

    // Out-of-range reads return zero rather than aliasing onto a real word.
    rd_word = '0;
    if (in_range) begin
      rd_word = mem_q[bus.address];
    end

    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        if (clr_addr_q == c_last_addr) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      ST_READY: begin
        // Writes are a read-modify-write of the addressed word so that
        // disabled bytes keep their previous contents.
        if (accept && bus.read_write && in_range) begin
          mem_we    = 1'b1;
          mem_waddr = bus.address;
          mem_wdata = rd_word;
          for (int b = 0; b < c_bytes; b++) begin
            if (bus.byte_en[b]) begin
              mem_wdata[8*b +: 8] = bus.data_in[8*b +: 8];
            end
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    addr_err_d = accept && !in_range;

    // Each stage only loads on a valid token so the last stage (data_out)
    // holds its value between read results.
    vld_d      = '0;
    vld_d[0]   = accept && !bus.read_write;
    pdata_d    = pdata_q;
    if (vld_d[0]) begin
      pdata_d[0] = rd_word;
    end
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) begin
        pdata_d[i] = pdata_q[i-1];
      end
    end
  end

  // Control state, error pulse and read pipeline registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
      vld_q      <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pdata_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready_q    <= ready_d;
      addr_err_q <= addr_err_d;
      vld_q      <= vld_d;
      pdata_q    <= pdata_d;
    end
  end

  // Storage array; never written while reset is held.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.data_out = pdata_q[RD_LAT-1];
  assign bus.rd_valid = vld_q[RD_LAT-1];
  assign bus.ready    = ready_q;
  assign bus.addr_err = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_sync_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_sync_bank                                           |
// | Description : Self-checking bench for mem_sync_bank. Two banks (16 and   |
// |               12 words) share one stimulus stream and are compared each  |
// |               cycle against a cycle-level behavioural model.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_sync_bank;
  localparam int          DATA_W = 16;
  localparam int          ADDR_W = 4;
  localparam int          RD_LAT = 2;
  localparam int          DEP0   = 16;
  localparam int          DEP1   = 12;
  localparam logic [15:0] INIT   = 16'hA5A5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst  = 1'b1;
  logic        cen  = 1'b0;
  logic        rw   = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] din  = '0;
  logic [1:0]  be   = '0;

  int nchecks = 0;
  int nerr    = 0;
  int cyc     = 0;

  mem_sync_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus0 ();
  mem_sync_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

  assign bus0.chip_en = cen;  assign bus1.chip_en = cen;
  assign bus0.read_write = rw; assign bus1.read_write = rw;
  assign bus0.address = addr; assign bus1.address = addr;
  assign bus0.data_in = din;  assign bus1.data_in = din;
  assign bus0.byte_en = be;   assign bus1.byte_en = be;

  mem_sync_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEP0), .RD_LAT(RD_LAT),
                  .INIT_VAL(INIT)) dut0 (.clock(clock), .reset(rst), .bus(bus0));
  mem_sync_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEP1), .RD_LAT(RD_LAT),
                  .INIT_VAL(INIT)) dut1 (.clock(clock), .reset(rst), .bus(bus1));

  // Behavioural model: word array, count of clear edges, and a schedule of
  // read results keyed by the cycle in which they must appear.
  logic [15:0] mem_m   [2][16];
  bit          sched_v [2][64];
  logic [15:0] sched_d [2][64];
  int          edges_m [2];
  bit          ready_m [2];
  bit          err_m   [2];
  bit          vld_m   [2];
  logic [15:0] dout_m  [2];

  function automatic int dep(input int d);
    return (d == 0) ? DEP0 : DEP1;
  endfunction

  function automatic void model_edge(input int d);
    int slot;
    if (rst) begin
      edges_m[d] = 0;
      ready_m[d] = 0;
      err_m[d]   = 0;
      dout_m[d]  = '0;
      for (int i = 0; i < 64; i++) sched_v[d][i] = 0;
    end else begin
      err_m[d] = 0;
      if (ready_m[d] && cen) begin
        if (int'(addr) >= dep(d)) err_m[d] = 1;
        if (rw) begin
          if (int'(addr) < dep(d))
            for (int b = 0; b < 2; b++)
              if (be[b]) mem_m[d][addr][8*b +: 8] = din[8*b +: 8];
        end else begin
          slot = (cyc + RD_LAT - 1) % 64;
          sched_v[d][slot] = 1;
          sched_d[d][slot] = (int'(addr) < dep(d)) ? mem_m[d][addr] : 16'h0000;
        end
      end
      if (!ready_m[d]) begin
        edges_m[d]++;
        if (edges_m[d] == dep(d)) begin
          ready_m[d] = 1;
          for (int i = 0; i < 16; i++) mem_m[d][i] = INIT;
        end
      end
    end
    vld_m[d] = sched_v[d][cyc % 64];
    if (vld_m[d]) dout_m[d] = sched_d[d][cyc % 64];
    sched_v[d][cyc % 64] = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("d0_ready",    32'(bus0.ready),    32'(ready_m[0]));
    chk("d0_rd_valid", 32'(bus0.rd_valid), 32'(vld_m[0]));
    chk("d0_addr_err", 32'(bus0.addr_err), 32'(err_m[0]));
    chk("d0_data_out", 32'(bus0.data_out), 32'(dout_m[0]));
    chk("d1_ready",    32'(bus1.ready),    32'(ready_m[1]));
    chk("d1_rd_valid", 32'(bus1.rd_valid), 32'(vld_m[1]));
    chk("d1_addr_err", 32'(bus1.addr_err), 32'(err_m[1]));
    chk("d1_data_out", 32'(bus1.data_out), 32'(dout_m[1]));
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    check_all();
  endtask

  task automatic op(input bit w, input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
    cen = 1'b1; rw = w; addr = a; din = d; be = b;
    step();
    cen = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a,
                            input logic [15:0] e0, input logic [15:0] e1);
    op(1'b0, a, 16'h0, 2'b00);
    for (int i = 1; i < RD_LAT; i++) step();
    chk({tag, "_v0"}, 32'(bus0.rd_valid), 32'd1);
    chk({tag, "_d0"}, 32'(bus0.data_out), 32'(e0));
    chk({tag, "_v1"}, 32'(bus1.rd_valid), 32'd1);
    chk({tag, "_d1"}, 32'(bus1.data_out), 32'(e1));
  endtask

  initial begin
    int r0, r1, nv;

    // Reset, then measure when each bank raises ready.
    rst = 1'b1;
    step();
    rst = 1'b0;
    r0 = -1; r1 = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (r0 < 0 && bus0.ready === 1'b1) r0 = k;
      if (r1 < 0 && bus1.ready === 1'b1) r1 = k;
    end
    chk("ready_rise0", 32'(r0), 32'd16);
    chk("ready_rise1", 32'(r1), 32'd12);

    // Every word reads back the clear pattern (out-of-range reads give 0).
    for (int a = 0; a < 16; a++)
      read_check("clr", 4'(a), INIT, (a < DEP1) ? INIT : 16'h0000);

    // Full write followed immediately by a read.
    op(1'b1, 4'd3, 16'h1234, 2'b11);
    read_check("wr_full", 4'd3, 16'h1234, 16'h1234);

    // Low-byte-only write, then an all-disabled write.
    op(1'b1, 4'd3, 16'hFFFF, 2'b01);
    read_check("wr_low", 4'd3, 16'h12FF, 16'h12FF);
    op(1'b1, 4'd3, 16'h0000, 2'b00);
    read_check("wr_none", 4'd3, 16'h12FF, 16'h12FF);

    // Back-to-back reads return in order on consecutive cycles.
    op(1'b1, 4'd1, 16'h1111, 2'b11);
    op(1'b1, 4'd2, 16'h2222, 2'b11);
    cen = 1'b1; rw = 1'b0;
    addr = 4'd1; step();
    addr = 4'd2; step();
    chk("b2b_v1", 32'(bus0.rd_valid), 32'd1);
    chk("b2b_d1", 32'(bus0.data_out), 32'h1111);
    addr = 4'd3; step();
    chk("b2b_v2", 32'(bus0.rd_valid), 32'd1);
    chk("b2b_d2", 32'(bus0.data_out), 32'h2222);
    cen = 1'b0; step();
    chk("b2b_v3", 32'(bus0.rd_valid), 32'd1);
    chk("b2b_d3", 32'(bus0.data_out), 32'h12FF);
    step();
    chk("b2b_end", 32'(bus0.rd_valid), 32'd0);

    // Out-of-range address on the 12-word bank.
    op(1'b1, 4'd13, 16'hBEEF, 2'b11);
    chk("oor_wr_err1", 32'(bus1.addr_err), 32'd1);
    chk("oor_wr_err0", 32'(bus0.addr_err), 32'd0);
    op(1'b0, 4'd13, 16'h0, 2'b00);
    chk("oor_rd_err1", 32'(bus1.addr_err), 32'd1);
    step();
    chk("oor_rd_v1", 32'(bus1.rd_valid), 32'd1);
    chk("oor_rd_d1", 32'(bus1.data_out), 32'h0000);
    chk("oor_rd_d0", 32'(bus0.data_out), 32'hBEEF);
    for (int a = 0; a < DEP1; a++)
      read_check("keep", 4'(a), mem_m[0][a], mem_m[1][a]);

    // Read accepted, then reset on the next edge with chip_en held in CLEAR.
    op(1'b0, 4'd5, 16'h0, 2'b00);
    rst = 1'b1; cen = 1'b1; rw = 1'b0; addr = 4'd5;
    step();
    rst = 1'b0;
    nv = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (bus0.rd_valid !== 1'b0) nv++;
    end
    chk("rst_no_valid", 32'(nv), 32'd0);
    cen = 1'b0;
    step(); step(); step();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      rst  = ($urandom_range(0, 99) == 0);
      cen  = 1'($urandom_range(0, 1));
      rw   = 1'($urandom_range(0, 1));
      addr = 4'($urandom_range(0, 15));
      din  = 16'($urandom);
      be   = 2'($urandom_range(0, 3));
      step();
    end
    rst = 1'b0; cen = 1'b0;
    for (int k = 0; k < 20; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
`default_nettype wire
